uart_rx_monitor: RTL and testbench
==================================

# uart_rx_monitor

Parametrised UART receive monitor for management-SoC and user-project DV benches and on-chip debug capture. It oversamples one serial line at a fixed integer divide and checks framing and optional parity. Good characters go into a show-ahead FIFO drained over a valid/ready port. It is the generalised successor to the fixed 8N1 bench receiver: configurable data width, oversampling ratio, buffer depth and parity, plus error reporting and idle detection.

## Interface
- CLKS_PER_BIT, 16: clock cycles per bit; integer ≥ 4.
- DATA_BITS, 8: data bits per character, 5..9.
- FIFO_DEPTH, 16: receive buffer entries; power of two ≥ 2.
- IDLE_CYCLES, 1024: high-line cycles after the last stop bit before `line_idle` asserts.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- ser_rx  in  1  serial input, asynchronous, idle high.
- parity_en  in  1  expect a parity bit after the data bits; quasi-static.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- rd_data  out  DATA_BITS  head-of-FIFO character.
- rd_valid  out  1  FIFO non-empty.
- rd_ready  in  1  pop when high with `rd_valid`.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  out  1  one-cycle pulse on parity mismatch.
- overflow  out  1  sticky; a character was dropped because the FIFO was full.
- clr_status  in  1  clears `overflow`.
- busy  out  1  receiver not in IDLE.
- line_idle  out  1  line has been quiet for IDLE_CYCLES.

## Operation
- `ser_rx` passes through a 2-flop synchroniser; both flops reset to 1.
- FSM states and transitions:
  - IDLE: a synchronised low moves to START; bit counter cleared.
  - START: waits CLKS_PER_BIT/2 cycles (integer divide), then samples. Low goes to DATA. High is a glitch and returns to IDLE, with no flags set.
  - DATA: samples every CLKS_PER_BIT cycles, LSB first, DATA_BITS samples. Then goes to PARITY if enabled, else STOP.
  - PARITY: one sample. XOR of data and parity bit must equal `parity_odd`.
  - STOP: one sample. High is a good stop. Low pulses `frame_err`, discards the character and goes to BREAK.
  - BREAK: waits for a synchronised high, then returns to IDLE.
- Push rule: the character is pushed on a good stop, but only if parity passed or parity is disabled. A parity failure pulses `parity_err` at the stop sample and drops the character.
- FIFO full at push with no pop in that cycle: the character is dropped and `overflow` is set.
- Push and pop in the same cycle, including when full: both take effect and the count is unchanged.
- Pop on an empty FIFO is ignored.
- `clr_status` and a new overflow in the same cycle: `overflow` stays set.
- Idle counter: cleared on any low synchronised sample. It increments while high, saturates at IDLE_CYCLES, and `line_idle` = (counter == IDLE_CYCLES).
- Reset mid-character: the FSM returns to IDLE and the FIFO empties. The partial character is lost and no error is flagged.

## Timing
- Reset values:
  - `rd_valid`=0, `rd_data`=0, `fifo_count`=0.
  - `frame_err`=0, `parity_err`=0, `overflow`=0.
  - `busy`=0, `line_idle`=0.
- Synchroniser latency is 2 cycles from a `ser_rx` edge.
- Let t0 be the cycle the FSM enters START. Bit k (start bit = 0) is sampled at t0 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT.
- `rd_valid` rises one cycle after the stop-bit sample. `rd_data` is stable while `rd_valid` is high and `rd_ready` is low.
- `frame_err` and `parity_err` are high for exactly the stop-sample cycle + 1.
- `busy` is high from START entry through the cycle before returning to IDLE.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state, `parity_en`/`parity_odd` logic and `parity_err` are all built.
- Undefined: `parity_en` and `parity_odd` are ignored, the PARITY state is absent, `parity_err` is tied 0, and every character is 1 start + DATA_BITS + 1 stop.

## Structure
- Package `uart_rx_pkg`: FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK) and the helper function for counter width.
- Sub-module `uart_rx_fifo`: synchronous show-ahead FIFO parametrised on width/depth, with push/pop/count and the full/empty rules above.

## Test plan
All scenarios use CLKS_PER_BIT=16, DATA_BITS=8, FIFO_DEPTH=16.
- Send 8N1 0x55 then 0xA3 with `rd_ready`=1 → two `rd_valid` beats with data 0x55 then 0xA3. No errors, and `rd_valid` rises 1 cycle after each stop sample.
- Send 0x3C with the stop bit held low for 2 bit times → one `frame_err` pulse, nothing pushed, `busy` stays high until the line returns high.
- Send 17 characters 0x00..0x10 with `rd_ready`=0 → `fifo_count`=16 and `overflow`=1. Draining yields 0x00..0x0F. `clr_status` then clears `overflow`.
- Drive a 4-cycle low pulse on an idle line → no push, no error, `busy` high for under 16 cycles.
- Parity build, `parity_en`=1, `parity_odd`=1: send 0x07 with parity bit 1 → `parity_err` pulse, no push. With parity bit 0 → 0x07 received.
- Assert `reset` mid-DATA of 0xFF, then send 0x12 → only 0x12 received and no error flags.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and helpers for the UART receive monitor
//
// Purpose: receiver FSM state encoding and a counter-width helper.
// Ports:   none (package).
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    // Bits needed to hold every value 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous show-ahead FIFO for received characters
//
// Purpose: stores characters; head entry is visible on rdata_o without a pop.
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   push_i, wdata_i      write request and character
//   pop_i                remove head entry (ignored when empty)
//   rdata_o              head entry, 0 when empty
//   valid_o, full_o      non-empty / full flags
//   count_o              occupancy 0..DEPTH
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // push when it is also being drained.
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - oversampling UART receiver with framing checks and FIFO
//
// Purpose: samples ser_rx at mid-bit, checks stop bit (and parity when the
// UART_RX_PARITY_EN macro is defined), buffers good characters.
// Ports:
//   clock, reset              clock, synchronous active-high reset
//   ser_rx                    asynchronous serial input, idle high
//   parity_en, parity_odd     parity enable / odd select (UART_RX_PARITY_EN only)
//   rd_data, rd_valid, rd_ready  show-ahead read port
//   fifo_count                buffer occupancy
//   frame_err, parity_err     one-cycle error pulses
//   overflow, clr_status      sticky drop flag and its clear
//   busy, line_idle           receiver activity / quiet-line indication
module uart_rx_monitor
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int IDLE_CYCLES  = 1024
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ser_rx,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    input  logic                          clr_status,
    output logic                          busy,
    output logic                          line_idle
);

    localparam int CW = cnt_width(CLKS_PER_BIT - 1);
    localparam int BW = cnt_width(DATA_BITS - 1);
    localparam int IW = cnt_width(IDLE_CYCLES);
    localparam logic [CW-1:0] HALF_C   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_C   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

    rx_state_e            state_q, state_d;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overflow_q, overflow_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic                 push, fifo_full;
`ifdef UART_RX_PARITY_EN
    logic                 par_ok_q, par_ok_d;
    logic                 parity_err_q, parity_err_d;
`else
    logic                 unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
`endif

    assign rx_s = sync_q[1];

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_ok_d     = par_ok_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (clk_cnt_q == HALF_C) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (clk_cnt_q == LAST_C) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = parity_en ? ST_PARITY : ST_STOP;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (clk_cnt_q == LAST_C) begin
                    clk_cnt_d = '0;
                    par_ok_d  = (((^shift_q) ^ rx_s) == parity_odd);
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (clk_cnt_q == LAST_C) begin
                    clk_cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (parity_en && !par_ok_q) begin
                            parity_err_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
`else
                        push = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                clk_cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A clear in the same cycle as a new drop leaves the flag set.
    assign overflow_d = (overflow_q && !clr_status) || (push && fifo_full && !rd_ready);

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (!rx_s) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q      <= 2'b11;
            state_q     <= ST_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            idle_cnt_q  <= '0;
`ifdef UART_RX_PARITY_EN
            par_ok_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q      <= {sync_q[0], ser_rx};
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            idle_cnt_q  <= idle_cnt_d;
`ifdef UART_RX_PARITY_EN
            par_ok_q     <= par_ok_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .reset_i (reset),
        .push_i  (push),
        .wdata_i (shift_q),
        .pop_i   (rd_ready),
        .rdata_o (rd_data),
        .valid_o (rd_valid),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != ST_IDLE);
    assign line_idle = (idle_cnt_q == IDLE_MAX);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb/tb_uart_rx_monitor.sv - self-checking bench for uart_rx_monitor
module tb_uart_rx_monitor;

    localparam int C    = 16;
    localparam int IDLE = 64;
    // ser_rx edge to rd_valid: 2 sync + 1 FSM entry + half bit + 9 bits + 1 push.
    localparam int LAT  = 3 + C/2 + 9*C + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ser_rx = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       rd_ready = 1'b0;
    logic       clr_status = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] fifo_count;
    logic       frame_err, parity_err, overflow, busy, line_idle;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int beats    = 0;
    int fe_cnt   = 0;
    int fe_cyc   = 0;
    int pe_cnt   = 0;
    int pe_cyc   = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    uart_rx_monitor #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (8),
        .FIFO_DEPTH   (16),
        .IDLE_CYCLES  (IDLE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ser_rx     (ser_rx),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overflow   (overflow),
        .clr_status (clr_status),
        .busy       (busy),
        .line_idle  (line_idle)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (frame_err) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
        if (parity_err) begin
            pe_cnt = pe_cnt + 1;
            pe_cyc = cyc;
        end
        if (busy) busy_cnt = busy_cnt + 1;
        if (rd_valid && rd_ready) begin
            beats = beats + 1;
            n_checks = n_checks + 1;
            if (sb_q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_char: got %h expected none", rd_data);
            end else begin
                mon_e = sb_q.pop_front();
                if (rd_data !== mon_e.d) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rd_data: got %h expected %h", rd_data, mon_e.d);
                end
                if (mon_e.c != 0) begin
                    n_checks = n_checks + 1;
                    if (cyc != mon_e.c) begin
                        n_fail = n_fail + 1;
                        $display("FAIL rd_valid_timing: got cycle %0d expected %0d", cyc, mon_e.c);
                    end
                end
            end
        end
    end

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ser_rx = bits[i];
            repeat (C) @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks += 8;
        if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (line_idle !== 1'b0) begin n_fail++; $display("FAIL reset_line_idle: got %b expected 0", line_idle); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (IDLE - 1) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (line_idle !== 1'b0) begin n_fail++; $display("FAIL line_idle_early: got %b expected 0", line_idle); end
        @(negedge clock);
        n_checks++;
        if (line_idle !== 1'b1) begin n_fail++; $display("FAIL line_idle_rise: got %b expected 1", line_idle); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_back_to_back();
        int fe0, pe0, b0;
        fe0 = fe_cnt; pe0 = pe_cnt; b0 = beats;
        rd_ready = 1'b1;
        sb_q.push_back('{8'h55, cyc + LAT});
        send_bits(16'({1'b1, 8'h55, 1'b0}), 10);
        sb_q.push_back('{8'hA3, cyc + LAT});
        send_bits(16'({1'b1, 8'hA3, 1'b0}), 10);
        for (int i = 0; i < 200 && beats < b0 + 2; i++) @(posedge clock);
        #1;
        n_checks += 3;
        if (beats != b0 + 2) begin n_fail++; $display("FAIL b2b_beats: got %0d expected %0d", beats - b0, 2); end
        if (fe_cnt != fe0 || pe_cnt != pe0) begin n_fail++; $display("FAIL b2b_errors: got %0d expected 0", fe_cnt - fe0 + pe_cnt - pe0); end
        if (line_idle !== 1'b0) begin n_fail++; $display("FAIL b2b_line_idle: got %b expected 0", line_idle); end
    endtask

    task automatic test_frame_err();
        int fe0, b0, k;
        fe0 = fe_cnt; b0 = beats; k = cyc;
        rd_ready = 1'b1;
        send_bits(16'({8'h3C, 1'b0}), 9);
        ser_rx = 1'b0;
        repeat (2*C) @(posedge clock);
        #1;
        ser_rx = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_held: got %b expected 1", busy); end
        @(negedge clock);
        n_checks += 5;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy_release: got %b expected 0", busy); end
        if (fe_cnt != fe0 + 1) begin n_fail++; $display("FAIL frame_err_count: got %0d expected 1", fe_cnt - fe0); end
        if (fe_cyc != k + LAT) begin n_fail++; $display("FAIL frame_err_cycle: got %0d expected %0d", fe_cyc, k + LAT); end
        if (beats != b0) begin n_fail++; $display("FAIL frame_err_push: got %0d expected 0", beats - b0); end
        if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL frame_err_count_fifo: got %0d expected 0", fifo_count); end
        @(posedge clock);
        #1;
    endtask

    task automatic test_glitch();
        int fe0, b0, bc0;
        fe0 = fe_cnt; b0 = beats; bc0 = busy_cnt;
        ser_rx = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        ser_rx = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        n_checks += 3;
        if (busy_cnt - bc0 != 9) begin n_fail++; $display("FAIL glitch_busy_cycles: got %0d expected 9", busy_cnt - bc0); end
        if (beats != b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL glitch_push: got %0d expected 0", fifo_count); end
        if (fe_cnt != fe0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_overflow();
        int b0;
        b0 = beats;
        rd_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sb_q.push_back('{8'(i), 0});
            send_bits(16'({1'b1, 8'(i), 1'b0}), 10);
        end
        repeat (4) @(posedge clock);
        #1;
        n_checks += 4;
        if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL ovf_fifo_count: got %0d expected 16", fifo_count); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_rd_valid: got %b expected 1", rd_valid); end
        if (rd_data !== 8'h00) begin n_fail++; $display("FAIL ovf_head_stable: got %h expected 00", rd_data); end
        rd_ready = 1'b1;
        for (int i = 0; i < 200 && beats < b0 + 16; i++) @(posedge clock);
        #1;
        repeat (2) @(posedge clock);
        #1;
        rd_ready = 1'b0;
        n_checks += 4;
        if (beats != b0 + 16) begin n_fail++; $display("FAIL ovf_drain_beats: got %0d expected 16", beats - b0); end
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL ovf_scoreboard_left: got %0d expected 0", sb_q.size()); end
        if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL ovf_drained_count: got %0d expected 0", fifo_count); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
        clr_status = 1'b1;
        @(posedge clock);
        #1;
        clr_status = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    endtask

    task automatic test_reset_mid();
        int fe0, pe0, b0;
        fe0 = fe_cnt; pe0 = pe_cnt; b0 = beats;
        rd_ready = 1'b1;
        ser_rx = 1'b0;
        repeat (C) @(posedge clock);
        #1;
        ser_rx = 1'b1;
        repeat (3*C) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy_after: got %b expected 0", busy); end
        @(posedge clock);
        #1;
        repeat (6*C) @(posedge clock);
        #1;
        sb_q.push_back('{8'h12, cyc + LAT});
        send_bits(16'({1'b1, 8'h12, 1'b0}), 10);
        for (int i = 0; i < 200 && beats < b0 + 1; i++) @(posedge clock);
        #1;
        n_checks += 2;
        if (beats != b0 + 1) begin n_fail++; $display("FAIL midreset_beats: got %0d expected 1", beats - b0); end
        if (fe_cnt != fe0 || pe_cnt != pe0) begin n_fail++; $display("FAIL midreset_errors: got %0d expected 0", fe_cnt - fe0 + pe_cnt - pe0); end
    endtask

    task automatic test_parity();
        int pe0, b0, k;
        pe0 = pe_cnt; b0 = beats;
        rd_ready = 1'b1;
        parity_en = 1'b1;
        parity_odd = 1'b1;
`ifdef UART_RX_PARITY_EN
        k = cyc;
        send_bits(16'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
        repeat (4) @(posedge clock);
        #1;
        n_checks += 3;
        if (pe_cnt != pe0 + 1) begin n_fail++; $display("FAIL parity_err_count: got %0d expected 1", pe_cnt - pe0); end
        if (pe_cyc != k + LAT + C) begin n_fail++; $display("FAIL parity_err_cycle: got %0d expected %0d", pe_cyc, k + LAT + C); end
        if (beats != b0) begin n_fail++; $display("FAIL parity_bad_push: got %0d expected 0", beats - b0); end
        sb_q.push_back('{8'h07, cyc + LAT + C});
        send_bits(16'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
`else
        k = cyc;
        sb_q.push_back('{8'h07, k + LAT});
        send_bits(16'({1'b1, 8'h07, 1'b0}), 10);
`endif
        for (int i = 0; i < 200 && beats < b0 + 1; i++) @(posedge clock);
        #1;
        n_checks += 2;
        if (beats != b0 + 1) begin n_fail++; $display("FAIL parity_good_beats: got %0d expected 1", beats - b0); end
`ifdef UART_RX_PARITY_EN
        if (pe_cnt != pe0 + 1) begin n_fail++; $display("FAIL parity_good_err: got %0d expected 1", pe_cnt - pe0); end
`else
        if (pe_cnt != pe0) begin n_fail++; $display("FAIL parity_ignored_err: got %0d expected 0", pe_cnt - pe0); end
`endif
        parity_en = 1'b0;
        parity_odd = 1'b0;
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_overflow();
        test_reset_mid();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected test completion");
        $fatal(1);
    end

endmodule
